sys_bridge: RTL

- CPU-side bus initiator that decodes CPU data accesses in the 0x7F00–0x7F3F device window and forwards them to two timer devices.
- Collects device and external interrupt lines into a pending/mask controller and drives the 6-bit HWInt vector to CP0.
- Sits between the MEM stage and the timer devices (timer0 at 0x7F00, timer1 at 0x7F10).
- Flags unmapped, unaligned and read-only-write accesses as bus errors.

---
 rtl/sys_bridge_pkg.sv | 39 +++
 rtl/bridge_intc.sv | 44 ++++
 rtl/sys_bridge.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sys_bridge_pkg.sv
// Shared definitions for the CPU-to-timer bridge: address map, register word
// indices, FSM states and interrupt bit positions.
package sys_bridge_pkg;

    localparam int unsigned NumIrqDefault = 6;
    localparam logic [31:0] BaseT0Default = 32'h0000_7F00;
    localparam logic [31:0] BaseT1Default = 32'h0000_7F10;
    localparam logic [31:0] BaseIcDefault = 32'h0000_7F30;

    // Word index within a 16-byte block (addr[3:2]).
    localparam logic [1:0] WordCtrl     = 2'd0;
    localparam logic [1:0] WordPreset   = 2'd1;
    localparam logic [1:0] WordCount    = 2'd2;
    localparam logic [1:0] WordUnmapped = 2'd3;
    localparam logic [1:0] WordIpend    = 2'd0;
    localparam logic [1:0] WordImask    = 2'd1;
    localparam logic [1:0] WordErraddr  = 2'd2;

    localparam int unsigned IrqT0 = 0;
    localparam int unsigned IrqT1 = 1;

    typedef enum logic {
        StIdle,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        TgtNone,
        TgtT0,
        TgtT1,
        TgtIc
    } tgt_e;

    // Blocks are 16-byte aligned, so only the upper address bits identify one.
    function automatic logic in_block(logic [27:0] addr_hi, logic [27:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/bridge_intc.sv
// Interrupt pending/mask controller: level inputs set IPEND, W1C clears it,
// and the masked result is registered onto hwint.
module bridge_intc #(
    parameter int unsigned NumIrq = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumIrq-1:0] irq_i,
    input  logic [NumIrq-1:0] clr_i,
    input  logic              mask_we_i,
    input  logic [NumIrq-1:0] mask_wdata_i,
    output logic [NumIrq-1:0] ipend_o,
    output logic [NumIrq-1:0] imask_o,
    output logic [NumIrq-1:0] hwint_o
);

    logic [NumIrq-1:0] ipend_q, ipend_d;
    logic [NumIrq-1:0] imask_q, imask_d;
    logic [NumIrq-1:0] hwint_q, hwint_d;

    always_comb begin
        // A line still asserted re-sets its bit even while being cleared.
        ipend_d = irq_i | (ipend_q & ~clr_i);
        imask_d = mask_we_i ? mask_wdata_i : imask_q;
        hwint_d = ipend_q & imask_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ipend_q <= '0;
            imask_q <= '0;
            hwint_q <= '0;
        end else begin
            ipend_q <= ipend_d;
            imask_q <= imask_d;
            hwint_q <= hwint_d;
        end
    end

    assign ipend_o = ipend_q;
    assign imask_o = imask_q;
    assign hwint_o = hwint_q;

endmodule

// File: rtl/sys_bridge.sv
// CPU-side bridge: decodes the 0x7F00-0x7F3F device window onto two timers and
// a local interrupt/error block, answering every request one cycle later.
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NumIrqDefault,
    parameter logic [31:0] BASE_T0 = BaseT0Default,
    parameter logic [31:0] BASE_T1 = BaseT1Default,
    parameter logic [31:0] BASE_IC = BaseIcDefault
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_re,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic               busy,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    output logic               dev0_we,
    output logic               dev1_we,
    input  logic [31:0]        dev0_rdata,
    input  logic [31:0]        dev1_rdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] hwint
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    tgt_e        tgt_q, tgt_d;
    logic        err_q, err_d;
    logic [31:0] erraddr_q, erraddr_d;

    tgt_e        req_tgt;
    logic        req_err;
    logic        resp;
    logic        ok_write;
    logic        ic_we;
    logic [31:0] ic_rdata;

    logic [NUM_IRQ-1:0] clr;
    logic               mask_we;
    logic [NUM_IRQ-1:0] ipend;
    logic [NUM_IRQ-1:0] imask;

    always_comb begin
        if (in_block(cpu_addr[31:4], BASE_T0[31:4])) begin
            req_tgt = TgtT0;
        end else if (in_block(cpu_addr[31:4], BASE_T1[31:4])) begin
            req_tgt = TgtT1;
        end else if (in_block(cpu_addr[31:4], BASE_IC[31:4])) begin
            req_tgt = TgtIc;
        end else begin
            req_tgt = TgtNone;
        end
        // Word 2 is read-only in every block (timer count, ERRADDR).
        req_err = (cpu_addr[1:0] != 2'b00) || (req_tgt == TgtNone) ||
                  (cpu_addr[3:2] == WordUnmapped) || (cpu_we && cpu_addr[3:2] == WordCount);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        tgt_d     = tgt_q;
        err_d     = err_q;
        erraddr_d = erraddr_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_re || cpu_we) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we;
                    tgt_d   = req_tgt;
                    err_d   = req_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (err_q) begin
                    erraddr_d = addr_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            tgt_q     <= TgtNone;
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            tgt_q     <= tgt_d;
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign resp      = (state_q == StResp);
    assign busy      = resp;
    assign cpu_ready = resp;
    assign cpu_err   = resp && err_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign ok_write  = resp && we_q && !err_q;
    assign dev0_we   = ok_write && (tgt_q == TgtT0);
    assign dev1_we   = ok_write && (tgt_q == TgtT1);
    assign ic_we     = ok_write && (tgt_q == TgtIc);
    assign mask_we   = ic_we && (addr_q[3:2] == WordImask);
    assign clr       = (ic_we && addr_q[3:2] == WordIpend) ? wdata_q[NUM_IRQ-1:0] : '0;

    always_comb begin
        ic_rdata = '0;
        case (addr_q[3:2])
            WordIpend:   ic_rdata[NUM_IRQ-1:0] = ipend;
            WordImask:   ic_rdata[NUM_IRQ-1:0] = imask;
            WordErraddr: ic_rdata = erraddr_q;
            default:     ic_rdata = '0;
        endcase
    end

    always_comb begin
        cpu_rdata = '0;
        if (resp && !err_q && !we_q) begin
            case (tgt_q)
                TgtT0:   cpu_rdata = dev0_rdata;
                TgtT1:   cpu_rdata = dev1_rdata;
                TgtIc:   cpu_rdata = ic_rdata;
                default: cpu_rdata = '0;
            endcase
        end
    end

    bridge_intc #(
        .NumIrq(NUM_IRQ)
    ) u_intc (
        .clk_i       (clk),
        .rst_ni      (reset),
        .irq_i       (irq_in),
        .clr_i       (clr),
        .mask_we_i   (mask_we),
        .mask_wdata_i(wdata_q[NUM_IRQ-1:0]),
        .ipend_o     (ipend),
        .imask_o     (imask),
        .hwint_o     (hwint)
    );

endmodule
